cache_fill_ctrl: RTL and testbench

Sequencer on the CPU side of the LRU tag calculator (cache_calc).
- Accepts CPU word-read requests and drives the calculator's lookup inputs (i_en, i_addr, i_change_block, i_ready_wr).
- Reads the cache data RAM on a hit.
- On a miss, fetches the word from backing memory, writes it into the data RAM, and sets the calculator's valid bit via o_ready_wr.
- Read-only (instruction/data read) path.

---
 rtl/cache_fill_ctrl.sv | 132 +++++++++++++
 tb/tb_cache_fill_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl.sv
// CPU-side read sequencer for the LRU tag calculator: lookup, hit read, miss fill.
// Optional hit/miss statistics counters are enabled with CACHE_FILL_STATS_EN.
module cache_fill_ctrl #(
  parameter int DATA_W = 32,
  parameter int STAT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_nreset,
  input  logic              i_cpu_req,
  input  logic [29:0]       i_cpu_addr,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_calc_en,
  output logic [29:0]       o_calc_addr,
  output logic              o_calc_change_block,
  output logic              o_calc_ready_wr,
  input  logic              i_calc_miss,
  input  logic [7:0]        i_calc_addr,
  output logic [7:0]        o_dram_addr,
  output logic              o_dram_we,
  output logic [DATA_W-1:0] o_dram_wdata,
  input  logic [DATA_W-1:0] i_dram_rdata,
  output logic              o_mem_req,
  output logic [29:0]       o_mem_addr,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
`ifdef CACHE_FILL_STATS_EN
  ,
  input  logic              i_stat_clr,
  output logic [STAT_W-1:0] o_hit_cnt,
  output logic [STAT_W-1:0] o_miss_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, LOOKUP, HIT_RD, MEM_REQ, FILL} state_t;

  state_t            state, state_nxt;
  logic [29:0]       addr_q;
  logic [7:0]        fill_addr_q;
  logic [DATA_W-1:0] data_q;
  logic              mem_first_q;

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) state <= IDLE;
    else           state <= state_nxt;
  end

  // The calculator exposes the newly allocated index one cycle after the miss,
  // so the fill index is captured on the first MEM_REQ cycle only.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      addr_q      <= '0;
      fill_addr_q <= '0;
      data_q      <= '0;
      mem_first_q <= 1'b0;
    end else begin
      mem_first_q <= (state == LOOKUP);
      if (state == IDLE && i_cpu_req)          addr_q      <= i_cpu_addr;
      if (state == MEM_REQ && mem_first_q)     fill_addr_q <= i_calc_addr;
      if (state == MEM_REQ && i_mem_rvalid)    data_q      <= i_mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_cpu_req) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = i_calc_miss ? MEM_REQ : HIT_RD;
      HIT_RD:  state_nxt = IDLE;
      MEM_REQ: if (i_mem_rvalid) state_nxt = FILL;
      FILL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_cpu_ack           = 1'b0;
    o_cpu_rdata         = '0;
    o_calc_en           = 1'b0;
    o_calc_addr         = addr_q;
    o_calc_change_block = 1'b0;
    o_calc_ready_wr     = 1'b0;
    o_dram_addr         = '0;
    o_dram_we           = 1'b0;
    o_dram_wdata        = '0;
    o_mem_req           = 1'b0;
    o_mem_addr          = '0;
    o_busy              = (state != IDLE);
    case (state)
      LOOKUP: begin
        o_calc_en           = 1'b1;
        o_calc_change_block = 1'b1;
        o_dram_addr         = i_calc_addr;
      end
      HIT_RD: begin
        o_cpu_ack   = 1'b1;
        o_cpu_rdata = i_dram_rdata;
      end
      MEM_REQ: begin
        o_mem_req  = 1'b1;
        o_mem_addr = addr_q;
      end
      FILL: begin
        o_dram_we       = 1'b1;
        o_dram_addr     = fill_addr_q;
        o_dram_wdata    = data_q;
        o_calc_ready_wr = 1'b1;
        o_cpu_ack       = 1'b1;
        o_cpu_rdata     = data_q;
      end
      default: ;
    endcase
  end

`ifdef CACHE_FILL_STATS_EN
  // Saturating counters; a clear overrides any increment in the same cycle.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else if (i_stat_clr) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (!i_calc_miss && o_hit_cnt != '1)  o_hit_cnt  <= o_hit_cnt + 1'b1;
      if (i_calc_miss && o_miss_cnt != '1)  o_miss_cnt <= o_miss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl; the tb plays the calculator, data RAM and memory.
module tb_cache_fill_ctrl;
`ifdef CACHE_FILL_STATS_EN
  localparam int SW = 4;
`else
  localparam int SW = 16;
`endif

  logic        clk = 1'b0, nreset = 1'b0;
  logic        cpu_req = 1'b0;
  logic [29:0] cpu_addr = '0;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        calc_en, calc_cb, calc_rw;
  logic [29:0] calc_addr_o;
  logic        calc_miss = 1'b0;
  logic [7:0]  calc_addr = '0;
  logic [7:0]  dram_addr;
  logic        dram_we;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;
`ifdef CACHE_FILL_STATS_EN
  logic          stat_clr = 1'b0;
  logic [SW-1:0] hit_cnt, miss_cnt;
`endif

  int checks = 0, failures = 0;

  cache_fill_ctrl #(.DATA_W(32), .STAT_W(SW)) dut (
    .i_clk(clk), .i_nreset(nreset),
    .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr),
    .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
    .o_calc_en(calc_en), .o_calc_addr(calc_addr_o),
    .o_calc_change_block(calc_cb), .o_calc_ready_wr(calc_rw),
    .i_calc_miss(calc_miss), .i_calc_addr(calc_addr),
    .o_dram_addr(dram_addr), .o_dram_we(dram_we), .o_dram_wdata(dram_wdata),
    .i_dram_rdata(dram_rdata),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_busy(busy)
`ifdef CACHE_FILL_STATS_EN
    , .i_stat_clr(stat_clr), .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Data RAM model: synchronous write, 1-cycle read latency.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (dram_we) ram[dram_addr] <= dram_wdata;
    dram_rdata <= ram[dram_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [29:0] addr;
    logic        miss;
    logic [7:0]  lk_idx;
    logic [7:0]  fill_idx;
    int          dly;
    logic [31:0] mdata;
    logic [31:0] exp;
  } vec_t;

  // Starts and ends at a negedge with the DUT in IDLE.
  task automatic txn(input vec_t v);
    chk("idle_busy", busy, 0);
    cpu_req = 1'b1; cpu_addr = v.addr;
    @(posedge clk); #1 calc_miss = v.miss; calc_addr = v.lk_idx;
    @(negedge clk);
    chk("lk_en", calc_en, 1);
    chk("lk_cb", calc_cb, 1);
    chk("lk_calc_addr", calc_addr_o, v.addr);
    chk("lk_dram_addr", dram_addr, v.lk_idx);
    chk("lk_ack", cpu_ack, 0);
    chk("lk_busy", busy, 1);
    @(posedge clk); #1;
    if (!v.miss) begin
      @(negedge clk);
      chk("hit_ack", cpu_ack, 1);
      chk("hit_rdata", cpu_rdata, v.exp);
      chk("hit_mem_req", mem_req, 0);
      chk("hit_we", dram_we, 0);
      chk("hit_en", calc_en, 0);
    end else begin
      calc_miss = 1'b0; calc_addr = v.fill_idx;
      for (int c = 1; c <= v.dly; c++) begin
        if (c == v.dly) begin mem_rvalid = 1'b1; mem_rdata = v.mdata; end
        @(negedge clk);
        chk("mr_req", mem_req, 1);
        chk("mr_addr", mem_addr, v.addr);
        chk("mr_ack", cpu_ack, 0);
        chk("mr_we", dram_we, 0);
        @(posedge clk); #1 calc_addr = 8'hEE; mem_rvalid = 1'b0; mem_rdata = '0;
      end
      @(negedge clk);
      chk("fill_we", dram_we, 1);
      chk("fill_addr", dram_addr, v.fill_idx);
      chk("fill_wdata", dram_wdata, v.mdata);
      chk("fill_rw", calc_rw, 1);
      chk("fill_ack", cpu_ack, 1);
      chk("fill_rdata", cpu_rdata, v.exp);
      chk("fill_mem_req", mem_req, 0);
    end
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  vec_t vecs[$];
  vec_t v;
  int   n_hit, n_miss;

  initial begin
    vecs.push_back('{30'h0000123, 1'b1, 8'h09, 8'h03, 3, 32'hDEADBEEF, 32'hDEADBEEF});
    vecs.push_back('{30'h0000123, 1'b0, 8'h03, 8'h00, 0, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{30'h0000124, 1'b1, 8'h04, 8'h04, 1, 32'hCAFE0004, 32'hCAFE0004});
    vecs.push_back('{30'h0000124, 1'b0, 8'h04, 8'h00, 0, 32'h0,        32'hCAFE0004});
    for (int i = 0; i < 9; i++)
      vecs.push_back('{30'((i + 1) << 8), 1'b1, 8'h00, 8'((i % 8) << 5), 2,
                       32'h1000_0000 + 32'(i), 32'h1000_0000 + 32'(i)});
    // First block was evicted by the ninth; revisit evicts the now-LRU slot 1.
    vecs.push_back('{30'h0000100, 1'b1, 8'h00, 8'h20, 2, 32'h1000_0000, 32'h1000_0000});
    vecs.push_back('{30'h0000900, 1'b0, 8'h00, 8'h00, 0, 32'h0,        32'h1000_0008});

    #12;
    chk("rst_ack", cpu_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_calc_addr", calc_addr_o, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_dram_addr", dram_addr, 0);
    chk("rst_we", dram_we, 0);
    chk("rst_rdata", cpu_rdata, 0);
    @(negedge clk); nreset = 1'b1;
    @(negedge clk);

    n_hit = 0; n_miss = 0;
    foreach (vecs[i]) begin
      txn(vecs[i]);
      if (vecs[i].miss) n_miss++; else n_hit++;
    end

`ifdef CACHE_FILL_STATS_EN
    chk("stat_miss", miss_cnt, n_miss);
    chk("stat_hit", hit_cnt, n_hit);
    v = '{30'h0000900, 1'b0, 8'h00, 8'h00, 0, 32'h0, 32'h1000_0008};
    stat_clr = 1'b1;
    txn(v);
    stat_clr = 1'b0;
    chk("stat_clr_hit", hit_cnt, 0);
    chk("stat_clr_miss", miss_cnt, 0);
    for (int i = 0; i < 15; i++) txn(v);
    chk("stat_full", hit_cnt, 15);
    txn(v);
    chk("stat_sat", hit_cnt, 15);
    chk("stat_sat_miss", miss_cnt, 0);
`endif

    // Reset in the middle of a fill.
    cpu_req = 1'b1; cpu_addr = 30'h0ABCDE12;
    @(posedge clk); #1 calc_miss = 1'b1; calc_addr = 8'h40;
    @(posedge clk); #1 calc_miss = 1'b0; calc_addr = 8'h60;
    @(negedge clk);
    chk("rm_req_before", mem_req, 1);
    #2 nreset = 1'b0;
    #1;
    chk("rm_req", mem_req, 0);
    chk("rm_busy", busy, 0);
    chk("rm_ack", cpu_ack, 0);
    chk("rm_we", dram_we, 0);
    chk("rm_calc_addr", calc_addr_o, 0);
    cpu_req = 1'b0;
    @(negedge clk); nreset = 1'b1;
    @(posedge clk); #1 mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("stale_busy", busy, 0);
    chk("stale_ack", cpu_ack, 0);
    chk("stale_we", dram_we, 0);
    @(posedge clk); #1 mem_rvalid = 1'b0;
    @(negedge clk);
    chk("stale_busy2", busy, 0);
    chk("stale_we2", dram_we, 0);
`ifdef CACHE_FILL_STATS_EN
    chk("rst_stat_hit", hit_cnt, 0);
`endif
    v = '{30'h0000900, 1'b0, 8'h00, 8'h00, 0, 32'h0, 32'h1000_0008};
    txn(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
